// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage ALU with iterative multiply/divide unit.
//
// Purpose:
//   Single-cycle integer ops (add/sub/logic/compare, mfhi/mflo) are registered
//   on the accepting edge. Signed/unsigned multiply (shift-add) and divide
//   (restoring) iterate one bit per clock and write the HI/LO registers.
//
// Ports:
//   clk          clock, all state on the rising edge
//   rst_n        synchronous active-low reset
//   in_valid     operation request
//   in_ready     high only while idle (request can be accepted)
//   a, b         operands (WIDTH bits)
//   alu_control  4-bit operation select
//   flush        aborts an in-flight op and blocks an incoming one
//   result       registered result; zero/overflow registered with it
//   out_valid    one-cycle pulse marking a valid result
//   hi, lo       HI/LO registers written by mult/div
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  input  logic             flush,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             out_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;     // product high half / partial remainder
  logic [WIDTH-1:0]   sh_q, sh_d;       // multiplier / dividend-then-quotient
  logic [WIDTH-1:0]   opd_q, opd_d;     // multiplicand / divisor
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               vld_q, vld_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  function automatic logic [WIDTH-1:0] abs_w(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] ? WIDTH'(-x) : WIDTH'(x);
  endfunction

  function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] x, input logic n);
    return n ? WIDTH'(-x) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] x, input logic n);
    return n ? (2*WIDTH)'(-x) : x;
  endfunction

  // Single-cycle datapath
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH-1:0]        sum, diff, alu_res;
  logic                    alu_ovf;

  assign a_s  = a;
  assign b_s  = b;
  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_control)
      4'b0000: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0001: begin
        alu_res = diff;
        // Subtraction overflows when a and ~b share a sign that the result lacks.
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0010: alu_res = a & b;
      4'b0011: alu_res = a | b;
      4'b0100: alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      4'b0101: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      4'b0110: alu_res = a ^ b;
      4'b0111: alu_res = ~(a | b);
      4'b1100: alu_res = hi_q;
      4'b1101: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // Iteration datapath
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh, div_sub;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic               op_signed, sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;

  assign mul_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opd_q} : {(WIDTH+1){1'b0}});
  assign div_sh   = {acc_q, sh_q[WIDTH-1]};
  assign div_sub  = div_sh - {1'b0, opd_q};
  assign div_ge   = (div_sh >= {1'b0, opd_q});
  assign prod_fix = cneg_2w({acc_q, sh_q}, neg_lo_q);

  // mult/div: opcode bit 0 selects unsigned
  assign op_signed = ~alu_control[0];
  assign sa        = op_signed & a[WIDTH-1];
  assign sb        = op_signed & b[WIDTH-1];
  assign mag_a     = op_signed ? abs_w(a) : a;
  assign mag_b     = op_signed ? abs_w(b) : b;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    opd_d    = opd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    vld_d    = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && !flush) begin
          if (alu_control[3:2] == 2'b10) begin
            is_div_d = alu_control[1];
            acc_d    = '0;
            cnt_d    = CNT_W'(WIDTH);
            if (alu_control[1]) begin
              sh_d     = mag_a;
              opd_d    = mag_b;
              neg_lo_d = sa ^ sb;
              neg_hi_d = sa;
              dz_d     = (b == '0);
              state_d  = S_DIV;
            end else begin
              sh_d     = mag_b;
              opd_d    = mag_a;
              neg_lo_d = sa ^ sb;
              neg_hi_d = sa ^ sb;
              dz_d     = 1'b0;
              state_d  = S_MUL;
            end
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            ovf_d    = alu_ovf;
            vld_d    = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          // Add-then-shift the {acc, sh} pair right by one.
          acc_d = mul_sum[WIDTH:1];
          sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
          sh_d  = {sh_q[WIDTH-2:0], div_ge};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          if (is_div_q) begin
            // Divide by zero: magnitude divide already leaves the remainder = |a|,
            // but the quotient is forced to all ones regardless of signs.
            lo_d = dz_q ? '1 : cneg_w(sh_q, neg_lo_q);
            hi_d = cneg_w(acc_q, neg_hi_q);
          end else begin
            lo_d = prod_fix[WIDTH-1:0];
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
          end
          result_d = lo_d;
          zero_d   = (lo_d == '0);
          ovf_d    = 1'b0;
          vld_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      vld_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      vld_q    <= vld_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    sh_q  <= sh_d;
    opd_q <= opd_d;
  end

  assign in_ready  = (state_q == S_IDLE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign out_valid = vld_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule
